bcd2bin_arbiter: RTL

Round-robin arbiter and sequencer that shares one `bcd2bin` converter among N requesters. Each requester presents a two-digit packed BCD operand with a level request. The arbiter grants one requester at a time, drives the converter's start/operand inputs, and waits for `done_tick`. It then returns the 7-bit binary result with a one-cycle per-requester acknowledge. It sits between the converter instance and the client logic (display/test FSMs) in the top level.

---
 rtl/bcd2bin_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/bcd2bin_arbiter.sv
// rtl/bcd2bin_arbiter.sv - round-robin sequencer sharing one bcd2bin converter among N requesters
// Optional operand digit check: define BCD2BIN_ARB_DIGIT_CHECK_EN.
module bcd2bin_arbiter #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [8*N-1:0]   bcd_in,
    output logic [N-1:0]     ack,
    output logic [6:0]       bin_out,
    output logic             err,
    output logic             busy,
    output logic             cv_start,
    output logic [3:0]       cv_bcd1,
    output logic [3:0]       cv_bcd0,
    input  logic             cv_done_tick,
    input  logic [6:0]       cv_bin
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic [7:0]    opnd;

    logic          win;
    logic [IW-1:0] win_idx;
    logic [7:0]    win_opnd;
    logic          digit_bad;

    assign cv_bcd1 = opnd[7:4];
    assign cv_bcd0 = opnd[3:0];

    // First set request at or after rr_ptr, wrapping explicitly so any N is legal.
    always_comb begin
        int            pos;
        logic [IW-1:0] cand;
        win     = 1'b0;
        win_idx = '0;
        pos     = 0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N)
                pos = pos - N;
            cand = IW'(pos);
            if (!win && req[cand]) begin
                win     = 1'b1;
                win_idx = cand;
            end
        end
        win_opnd = bcd_in[8*win_idx +: 8];
    end

`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
    assign digit_bad = (win_opnd[7:4] > 4'd9) || (win_opnd[3:0] > 4'd9);
`else
    assign digit_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            opnd     <= '0;
            ack      <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            cv_start <= 1'b0;
            bin_out  <= '0;
        end else begin
            ack      <= '0;
            err      <= 1'b0;
            cv_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (win) begin
                        gnt_idx <= win_idx;
                        opnd    <= win_opnd;
                        busy    <= 1'b1;
                        if (digit_bad) begin
                            // Rejected operands never reach the converter.
                            state <= DONE;
                            ack   <= ONE_HOT0 << win_idx;
                            err   <= 1'b1;
                        end else begin
                            state    <= START;
                            cv_start <= 1'b1;
                        end
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (cv_done_tick) begin
                        bin_out <= cv_bin;
                        ack     <= ONE_HOT0 << gnt_idx;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
